// File: rtl/seq_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_tx : serial word transmitter with programmable repeats and idle gaps   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seq_tx #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data,
  input  logic [3:0]                 reps,
  output logic                       out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH)-1:0]   bit_idx
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [3:0]       rep_q, rep_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;

  logic [WIDTH-1:0] w_shifted;
  logic             w_first_d;

  // Bit order only changes which end is sent and which way the register moves.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {shift_q[WIDTH-2:0], 1'b0};
      assign w_first_d = shift_d[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, shift_q[WIDTH-1:1]};
      assign w_first_d = shift_d[0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    word_d  = word_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_d  = data;
          shift_d = data;
          rep_d   = (reps == 4'd0) ? 4'd1 : reps;
          bit_d   = '0;
          gap_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_q == BIT_LAST) begin
          rep_d = rep_q - 4'd1;
          bit_d = '0;
          if (rep_q > 4'd1) begin
            if (GAP > 0) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              shift_d = word_q;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          shift_d = w_shifted;
          bit_d   = bit_q + BW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          shift_d = word_q;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they align with state_q.
  always_comb begin
    out_d     = (state_d == S_SHIFT) & w_first_d;
    busy_d    = (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
    bit_idx_d = (state_d == S_SHIFT) ? bit_d : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      word_q    <= '0;
      rep_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      rep_q     <= rep_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_tx : directed bench for seq_tx (MSB/GAP=2, LSB/GAP=2, MSB/GAP=0)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seq_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] reps = 4'd0;

  logic       m_out, m_busy, m_done;
  logic [2:0] m_idx;
  logic       l_out, l_busy, l_done;
  logic [2:0] l_idx;
  logic       z_out, z_busy, z_done;
  logic [2:0] z_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .data(data), .reps(reps),
    .out(m_out), .busy(m_busy), .done(m_done), .bit_idx(m_idx));

  seq_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rstn(rstn), .start(start), .data(data), .reps(reps),
    .out(l_out), .busy(l_busy), .done(l_done), .bit_idx(l_idx));

  seq_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u_gap0 (
    .clk(clk), .rstn(rstn), .start(start), .data(data), .reps(reps),
    .out(z_out), .busy(z_busy), .done(z_done), .bit_idx(z_idx));

  // Pulses start for one edge; returns at the negedge of cycle 1 after accept.
  task automatic kick(input logic [7:0] d, input logic [3:0] r);
    @(negedge clk);
    start = 1'b1; data = d; reps = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({m_out, m_busy, m_done, m_idx} !== 6'b0) begin
      bad++; $display("FAIL reset_msb got=%b want=000000", {m_out, m_busy, m_done, m_idx});
    end
    total++;
    if ({l_out, l_busy, l_done, l_idx, z_out, z_busy, z_done, z_idx} !== 12'b0) begin
      bad++; $display("FAIL reset_others got=%b want=0", {l_out, l_busy, l_done, l_idx, z_out, z_busy, z_done, z_idx});
    end
    @(negedge clk);
    rstn = 1'b1;
    settle(2);
  endtask

  task automatic test_msb_reps1;
    logic [7:0] exp = 8'b1011_0101;
    kick(8'hB5, 4'd1);
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({m_out, m_busy, m_done, m_idx} !== {exp[7-i], 1'b1, 1'b0, 3'(i)}) begin
        bad++; $display("FAIL msb1_bit%0d got o/b/d/i=%b/%b/%b/%0d want %b/1/0/%0d", i, m_out, m_busy, m_done, m_idx, exp[7-i], i);
      end
      @(negedge clk);
    end
    total++;
    if ({m_out, m_busy, m_done, m_idx} !== 6'b001000) begin
      bad++; $display("FAIL msb1_done got=%b want=001000", {m_out, m_busy, m_done, m_idx});
    end
    @(negedge clk);
    total++;
    if ({m_out, m_busy, m_done} !== 3'b000) begin
      bad++; $display("FAIL msb1_after got=%b want=000", {m_out, m_busy, m_done});
    end
    settle(30);
  endtask

  task automatic test_reps3;
    logic [7:0] exp = 8'hB5;
    int busy_cnt = 0;
    kick(8'hB5, 4'd3);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) begin
        busy_cnt += int'(m_busy);
        total++;
        if ({m_out, m_busy, m_done, m_idx} !== {exp[7-i], 1'b1, 1'b0, 3'(i)}) begin
          bad++; $display("FAIL rep3_w%0d_b%0d got o/b/d/i=%b/%b/%b/%0d want %b/1/0/%0d", w, i, m_out, m_busy, m_done, m_idx, exp[7-i], i);
        end
        @(negedge clk);
      end
      if (w < 2) begin
        for (int g = 0; g < 2; g++) begin
          busy_cnt += int'(m_busy);
          total++;
          if ({m_out, m_busy, m_done, m_idx} !== 6'b010000) begin
            bad++; $display("FAIL rep3_gap%0d_%0d got=%b want=010000", w, g, {m_out, m_busy, m_done, m_idx});
          end
          @(negedge clk);
        end
      end
    end
    total++;
    if (busy_cnt !== 28) begin
      bad++; $display("FAIL rep3_busy_cycles got=%0d want=28", busy_cnt);
    end
    total++;
    if ({m_out, m_busy, m_done} !== 3'b001) begin
      bad++; $display("FAIL rep3_done got=%b want=001", {m_out, m_busy, m_done});
    end
    @(negedge clk);
    total++;
    if (m_done !== 1'b0) begin
      bad++; $display("FAIL rep3_done_width got=%b want=0", m_done);
    end
    settle(10);
  endtask

  task automatic test_lsb_reps0;
    logic [7:0] seq = 8'b1010_1101;  // expected serial order, index 7 first
    kick(8'hB5, 4'd0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({l_out, l_busy, l_idx} !== {seq[7-i], 1'b1, 3'(i)}) begin
        bad++; $display("FAIL lsb0_bit%0d got o/b/i=%b/%b/%0d want %b/1/%0d", i, l_out, l_busy, l_idx, seq[7-i], i);
      end
      @(negedge clk);
    end
    total++;
    if ({l_out, l_busy, l_done} !== 3'b001) begin
      bad++; $display("FAIL lsb0_done got=%b want=001", {l_out, l_busy, l_done});
    end
    settle(30);
  endtask

  task automatic test_gap0;
    logic [7:0] exp = 8'hA5;
    kick(8'hA5, 4'd2);
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({z_out, z_busy, z_done, z_idx} !== {exp[7-(i%8)], 1'b1, 1'b0, 3'(i%8)}) begin
        bad++; $display("FAIL gap0_bit%0d got o/b/d/i=%b/%b/%b/%0d want %b/1/0/%0d", i, z_out, z_busy, z_done, z_idx, exp[7-(i%8)], i%8);
      end
      @(negedge clk);
    end
    total++;
    if ({z_out, z_busy, z_done} !== 3'b001) begin
      bad++; $display("FAIL gap0_done got=%b want=001", {z_out, z_busy, z_done});
    end
    settle(30);
  endtask

  task automatic test_start_held;
    logic [7:0] exp = 8'hB5;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; data = 8'hB5; reps = 4'd1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) data = 8'h00;
      dones += int'(m_done);
      total++;
      if ({m_out, m_busy} !== {exp[7-i], 1'b1}) begin
        bad++; $display("FAIL held_bit%0d got o/b=%b/%b want %b/1", i, m_out, m_busy, exp[7-i]);
      end
      @(negedge clk);
    end
    dones += int'(m_done);
    @(negedge clk);
    dones += int'(m_done);
    total++;
    if ({m_out, m_busy, m_done} !== 3'b000) begin
      bad++; $display("FAIL held_idle got=%b want=000", {m_out, m_busy, m_done});
    end
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL held_done_count got=%0d want=1", dones);
    end
    @(negedge clk);
    total++;
    if ({m_out, m_busy, m_idx} !== 5'b01000) begin
      bad++; $display("FAIL held_restart got=%b want=01000", {m_out, m_busy, m_idx});
    end
    settle(40);
  endtask

  task automatic test_reset_midjob;
    int dones = 0;
    kick(8'hB5, 4'd3);
    repeat (4) @(negedge clk);
    total++;
    if ({m_busy, m_idx} !== 4'b1100) begin
      bad++; $display("FAIL rst_pre got b/i=%b/%0d want 1/4", m_busy, m_idx);
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({m_out, m_busy, m_done, m_idx} !== 6'b0) begin
      bad++; $display("FAIL rst_async got=%b want=000000", {m_out, m_busy, m_done, m_idx});
    end
    repeat (2) begin
      @(negedge clk);
      dones += int'(m_done);
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      dones += int'(m_done);
    end
    total++;
    if (dones !== 0 || m_busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_done got dones/busy=%0d/%b want 0/0", dones, m_busy);
    end
    kick(8'hFF, 4'd1);
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({m_out, m_busy, m_idx} !== {2'b11, 3'(i)}) begin
        bad++; $display("FAIL rst_ff_bit%0d got o/b/i=%b/%b/%0d want 1/1/%0d", i, m_out, m_busy, m_idx, i);
      end
      @(negedge clk);
    end
    total++;
    if (m_done !== 1'b1) begin
      bad++; $display("FAIL rst_ff_done got=%b want=1", m_done);
    end
    settle(30);
  endtask

  task automatic test_reps15;
    int mb = 0, zb = 0, md = 0, zd = 0;
    kick(8'hA5, 4'd15);
    for (int c = 0; c < 170; c++) begin
      mb += int'(m_busy); zb += int'(z_busy);
      md += int'(m_done); zd += int'(z_done);
      @(negedge clk);
    end
    total++;
    if (mb !== 148 || md !== 1) begin
      bad++; $display("FAIL rep15_gap2 got busy/done=%0d/%0d want 148/1", mb, md);
    end
    total++;
    if (zb !== 120 || zd !== 1) begin
      bad++; $display("FAIL rep15_gap0 got busy/done=%0d/%0d want 120/1", zb, zd);
    end
    settle(5);
  endtask

  initial begin
    test_reset;
    test_msb_reps1;
    test_reps3;
    test_lsb_reps0;
    test_gap0;
    test_start_held;
    test_reset_midjob;
    test_reps15;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
